// File: rtl/traffic_signal_timed.sv
// Timed highway/country-road signal controller: per-phase dwell timers, min/max greens, latched car request.
// Optional night-flash mode is compiled in by defining FLASH_MODE_EN.
module traffic_signal_timed #(
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2,
  parameter int T_CR_MIN    = 5,
  parameter int T_CR_MAX    = 20,
  parameter int T_FLASH     = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             signal,
`ifdef FLASH_MODE_EN
  input  logic             flash,
`endif
  output logic [2:0]       highway,
  output logic [2:0]       country_road,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer
);

  localparam logic [2:0] HW_GREEN  = 3'd0;
  localparam logic [2:0] HW_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED1  = 3'd2;
  localparam logic [2:0] CR_GREEN  = 3'd3;
  localparam logic [2:0] CR_YELLOW = 3'd4;
  localparam logic [2:0] ALL_RED2  = 3'd5;
`ifdef FLASH_MODE_EN
  localparam logic [2:0] FLASH     = 3'd6;
`endif

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
`ifdef FLASH_MODE_EN
  localparam logic [2:0] LAMP_OFF    = 3'b000;
`endif

  localparam logic [CNT_W-1:0] LD_MIN_GREEN = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_CR_MIN    = CNT_W'(T_CR_MIN - 1);
  localparam logic [CNT_W-1:0] CR_LAST      = CNT_W'(T_CR_MAX - 1);
`ifdef FLASH_MODE_EN
  localparam logic [CNT_W-1:0] LD_FLASH     = CNT_W'(T_FLASH - 1);
`endif

  // Every dwell must be at least one cycle and representable by the timer.
  localparam int N_T = 6;
  localparam int T_ARR [N_T] = '{T_MIN_GREEN, T_YELLOW, T_ALL_RED, T_CR_MIN, T_CR_MAX, T_FLASH};

  genvar gi;
  generate
    for (gi = 0; gi < N_T; gi++) begin : g_tchk
      if (T_ARR[gi] < 1 || longint'(T_ARR[gi]) >= (longint'(1) << CNT_W)) begin : g_bad
        $error("traffic_signal_timed: dwell parameter %0d out of range", gi);
      end
    end
    if (T_CR_MAX < T_CR_MIN) begin : g_bad_cr
      $error("traffic_signal_timed: T_CR_MAX must be >= T_CR_MIN");
    end
  endgenerate

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] cr_elapsed_reg, cr_elapsed_next;
  logic             req_reg, req_next;
  logic             tmr_zero;
`ifdef FLASH_MODE_EN
  logic             blink_reg, blink_next;
`endif

  assign tmr_zero = (timer_reg == '0);

  always_comb begin
    state_next      = state_reg;
    timer_next      = tmr_zero ? '0 : timer_reg - 1'b1;
    cr_elapsed_next = cr_elapsed_reg;
    req_next        = req_reg | (signal && (state_reg != CR_GREEN));
`ifdef FLASH_MODE_EN
    blink_next      = blink_reg;
`endif
    case (state_reg)
      HW_GREEN: begin
        if (tmr_zero && (req_reg || signal)) begin
          state_next = HW_YELLOW;
          timer_next = LD_YELLOW;
        end
      end
      HW_YELLOW: begin
        if (tmr_zero) begin
          state_next = ALL_RED1;
          timer_next = LD_ALL_RED;
        end
      end
      ALL_RED1: begin
        if (tmr_zero) begin
          state_next      = CR_GREEN;
          timer_next      = LD_CR_MIN;
          cr_elapsed_next = '0;
          req_next        = 1'b0;
        end
      end
      CR_GREEN: begin
        // Minimum green is the timer; maximum green is the elapsed count.
        cr_elapsed_next = cr_elapsed_reg + 1'b1;
        if (tmr_zero && (!signal || cr_elapsed_reg == CR_LAST)) begin
          state_next = CR_YELLOW;
          timer_next = LD_YELLOW;
        end
      end
      CR_YELLOW: begin
        if (tmr_zero) begin
          state_next = ALL_RED2;
          timer_next = LD_ALL_RED;
        end
      end
      ALL_RED2: begin
        if (tmr_zero) begin
          state_next = HW_GREEN;
          timer_next = LD_MIN_GREEN;
        end
      end
`ifdef FLASH_MODE_EN
      FLASH: begin
        if (!flash) begin
          state_next = ALL_RED2;
          timer_next = LD_ALL_RED;
        end else if (tmr_zero) begin
          blink_next = ~blink_reg;
          timer_next = LD_FLASH;
        end
      end
`endif
      default: begin
        state_next = HW_GREEN;
        timer_next = LD_MIN_GREEN;
      end
    endcase
`ifdef FLASH_MODE_EN
    // Flash request pre-empts every phase; the car request survives it.
    if (flash && state_reg != FLASH) begin
      state_next = FLASH;
      timer_next = LD_FLASH;
      blink_next = 1'b1;
      req_next   = req_reg | (signal && (state_reg != CR_GREEN));
    end
`endif
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg      <= HW_GREEN;
      timer_reg      <= LD_MIN_GREEN;
      cr_elapsed_reg <= '0;
      req_reg        <= 1'b0;
`ifdef FLASH_MODE_EN
      blink_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      cr_elapsed_reg <= cr_elapsed_next;
      req_reg        <= req_next;
`ifdef FLASH_MODE_EN
      blink_reg      <= blink_next;
`endif
    end
  end

  always_comb begin
    highway      = LAMP_RED;
    country_road = LAMP_RED;
    case (state_reg)
      HW_GREEN:  highway      = LAMP_GREEN;
      HW_YELLOW: highway      = LAMP_YELLOW;
      CR_GREEN:  country_road = LAMP_GREEN;
      CR_YELLOW: country_road = LAMP_YELLOW;
`ifdef FLASH_MODE_EN
      FLASH: begin
        highway      = blink_reg ? LAMP_YELLOW : LAMP_OFF;
        country_road = blink_reg ? LAMP_RED : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign phase = state_reg;
  assign timer = timer_reg;

endmodule

// File: tb/tb_traffic_signal_timed.sv
// Bench for traffic_signal_timed: spec vector table, hand-written corner sequences,
// and random car traffic checked against an elapsed-time reference model.
module tb_traffic_signal_timed;

  localparam int CNT_W = 8;
  localparam int TMG   = 4;
  localparam int TY    = 2;
  localparam int TAR   = 1;
  localparam int TCMIN = 3;
  localparam int TCMAX = 6;
  localparam int TFL   = 4;
`ifdef FLASH_MODE_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             signal = 1'b0;
`ifdef FLASH_MODE_EN
  logic             flash = 1'b0;
`endif
  logic [2:0]       highway, country_road, phase;
  logic [CNT_W-1:0] timer;

  traffic_signal_timed #(
    .CNT_W(CNT_W), .T_MIN_GREEN(TMG), .T_YELLOW(TY), .T_ALL_RED(TAR),
    .T_CR_MIN(TCMIN), .T_CR_MAX(TCMAX), .T_FLASH(TFL)
  ) dut (
    .clk(clk),
    .clear(clear),
    .signal(signal),
`ifdef FLASH_MODE_EN
    .flash(flash),
`endif
    .highway(highway),
    .country_road(country_road),
    .phase(phase),
    .timer(timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ph_hist [64];
  int hw_hist [64];

  // Reference model: phase number, cycles spent in the phase, latched request.
  int m_ph, m_el;
  bit m_req;

  typedef struct {
    bit sig;
    int ph;
    int tmr;
  } vec_t;
  vec_t pulse_tbl [14];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int dwell(input int ph);
    case (ph)
      0: return TMG;
      1: return TY;
      2: return TAR;
      3: return TCMIN;
      4: return TY;
      5: return TAR;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_timer();
    int t;
    if (m_ph == 6) return TFL - 1 - (m_el % TFL);
    t = dwell(m_ph) - 1 - m_el;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int exp_hw();
    bit bl = ((m_el / TFL) % 2) == 0;
    case (m_ph)
      0: return 1;
      1: return 2;
      6: return bl ? 2 : 0;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_cr();
    bit bl = ((m_el / TFL) % 2) == 0;
    case (m_ph)
      3: return 1;
      4: return 2;
      6: return bl ? 4 : 0;
      default: return 4;
    endcase
  endfunction

  task automatic model_step(input bit sig, input bit fl);
    int  nph  = m_ph;
    bit  nreq = m_req || (sig && m_ph != 3);
    bit  done = m_el >= dwell(m_ph) - 1;
    if (FLASH_EN && fl) begin
      nph = 6;
    end else begin
      case (m_ph)
        0: if (done && (m_req || sig)) nph = 1;
        1: if (done) nph = 2;
        2: if (done) nph = 3;
        3: if (done && (!sig || m_el == TCMAX - 1)) nph = 4;
        4: if (done) nph = 5;
        5: if (done) nph = 0;
        6: nph = 5;
        default: nph = 0;
      endcase
    end
    if (nph == 3 && m_ph != 3) nreq = 1'b0;
    m_el  = (nph == m_ph) ? m_el + 1 : 0;
    m_ph  = nph;
    m_req = nreq;
  endtask

  task automatic run_cycle(input bit sig, input bit fl);
    signal = sig;
`ifdef FLASH_MODE_EN
    flash = fl;
`endif
    chk("phase", int'(phase), m_ph);
    chk("timer", int'(timer), exp_timer());
    chk("highway", int'(highway), exp_hw());
    chk("country_road", int'(country_road), exp_cr());
    if (cyc < 64) begin
      ph_hist[cyc] = int'(phase);
      hw_hist[cyc] = int'(highway);
    end
    model_step(sig, fl);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    clear  = 1'b0;
    signal = 1'b0;
`ifdef FLASH_MODE_EN
    flash  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_phase", int'(phase), 0);
    chk("reset_timer", int'(timer), TMG - 1);
    clear = 1'b1;
    m_ph  = 0;
    m_el  = 0;
    m_req = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int  sig_mode;
    int  fl_hold;
    bit  s, f;

    pulse_tbl[0]  = '{1'b0, 0, 3};
    pulse_tbl[1]  = '{1'b1, 0, 2};
    pulse_tbl[2]  = '{1'b0, 0, 1};
    pulse_tbl[3]  = '{1'b0, 0, 0};
    pulse_tbl[4]  = '{1'b0, 1, 1};
    pulse_tbl[5]  = '{1'b0, 1, 0};
    pulse_tbl[6]  = '{1'b0, 2, 0};
    pulse_tbl[7]  = '{1'b0, 3, 2};
    pulse_tbl[8]  = '{1'b0, 3, 1};
    pulse_tbl[9]  = '{1'b0, 3, 0};
    pulse_tbl[10] = '{1'b0, 4, 1};
    pulse_tbl[11] = '{1'b0, 4, 0};
    pulse_tbl[12] = '{1'b0, 5, 0};
    pulse_tbl[13] = '{1'b0, 0, 3};

    #1;
    // Idle: highway green holds indefinitely with no car.
    do_reset();
    for (int i = 0; i < 50; i++) run_cycle(1'b0, 1'b0);
    $display("idle: 50 cycles, phase=%0d timer=%0d", phase, timer);

    // Single-cycle car pulse, checked against the literal vector table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk("tbl_phase", int'(phase), pulse_tbl[i].ph);
      chk("tbl_timer", int'(timer), pulse_tbl[i].tmr);
      run_cycle(pulse_tbl[i].sig, 1'b0);
    end
    $display("pulse: 14 vectors applied");

    // Car held: country green capped at max, request relatched for next cycle.
    do_reset();
    for (int i = 0; i < 22; i++) run_cycle(1'b1, 1'b0);
    chk("held_c6", ph_hist[6], 2);
    chk("held_c7", ph_hist[7], 3);
    chk("held_c12", ph_hist[12], 3);
    chk("held_c13", ph_hist[13], 4);
    chk("held_c16", ph_hist[16], 0);
    chk("held_c19", ph_hist[19], 0);
    chk("held_c20", ph_hist[20], 1);
    $display("held: country green cycles 7-12, yellow at 13, hw yellow at 20");

    // Car seen only during ALL_RED2 still earns a full highway minimum first.
    do_reset();
    for (int i = 0; i < 19; i++) run_cycle(i == 1 || i == 12, 1'b0);
    chk("ar2_c12", ph_hist[12], 5);
    chk("ar2_c13", ph_hist[13], 0);
    chk("ar2_c16", ph_hist[16], 0);
    chk("ar2_c17", ph_hist[17], 1);
    $display("all_red2 car: hw green 13-16, yellow at 17");

    // Asynchronous reset in the middle of country green.
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(i == 1, 1'b0);
    chk("pre_rst_phase", int'(phase), 3);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    chk("async_hw", int'(highway), 1);
    chk("async_cr", int'(country_road), 4);
    chk("async_phase", int'(phase), 0);
    chk("async_timer", int'(timer), TMG - 1);
    do_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);
    $display("async reset: lamps returned before next edge");

    // Reset must drop a pending request.
    do_reset();
    run_cycle(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);
    chk("req_cleared", ph_hist[9], 0);
    $display("reset clears req: hw green held");

`ifdef FLASH_MODE_EN
    do_reset();
    for (int i = 0; i < 28; i++) run_cycle(1'b0, i >= 2 && i < 22);
    chk("fl_c3", hw_hist[3], 2);
    chk("fl_c6", hw_hist[6], 2);
    chk("fl_c7", hw_hist[7], 0);
    chk("fl_c11", hw_hist[11], 2);
    chk("fl_c23", ph_hist[23], 5);
    chk("fl_c24", ph_hist[24], 0);
    $display("flash: blink every %0d cycles, exit via all-red", TFL);
`endif

    // Random traffic against the reference model.
    do_reset();
    sig_mode = 0;
    fl_hold  = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) sig_mode = $urandom_range(0, 2);
      s = (sig_mode == 2) ? 1'b1 : (sig_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (FLASH_EN && fl_hold == 0 && $urandom_range(0, 99) == 0) fl_hold = $urandom_range(3, 15);
      f = fl_hold > 0;
      if (fl_hold > 0) fl_hold--;
      run_cycle(s, f);
    end
    $display("random: 800 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_signal_timed.md
Name: traffic_signal_timed

Overview:
- Parametrised successor to the fixed-step highway/country-road controller.
- Each phase has a configurable dwell time measured in clock cycles.
- Adds minimum highway green, minimum/maximum country-road green, a latched car request, and a status readout.
- Sits at the same place in the intersection design: drives the two 3-bit RYG lamp buses from the country-road car sensor.

Parameters:
- CNT_W, 8: width of the dwell timer and the status timer output.
- T_MIN_GREEN, 10: minimum highway green, in cycles.
- T_YELLOW, 3: yellow dwell for both roads, in cycles.
- T_ALL_RED, 2: all-red clearance dwell, in cycles.
- T_CR_MIN, 5: minimum country-road green, in cycles.
- T_CR_MAX, 20: maximum country-road green, in cycles. Must satisfy T_CR_MAX >= T_CR_MIN.
- T_FLASH, 4: half-period of the flash blink, in cycles (used only with FLASH_MODE_EN).
- All T_* values must be >= 1 and must fit in CNT_W bits. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- signal  input  1  country-road car present; synchronous to clk.
- highway  output  3  highway lamps, RYG one-hot (RED=100, YELLOW=010, GREEN=001).
- country_road  output  3  country-road lamps, same encoding.
- phase  output  3  current state code.
- timer  output  CNT_W  remaining dwell count.
- flash  input  1  night flash request (FLASH_MODE_EN only).

Behaviour:
- States and codes:
  - HW_GREEN=0: highway GREEN, country RED.
  - HW_YELLOW=1: highway YELLOW, country RED.
  - ALL_RED1=2: both RED.
  - CR_GREEN=3: highway RED, country GREEN.
  - CR_YELLOW=4: highway RED, country YELLOW.
  - ALL_RED2=5: both RED.
  - FLASH=6: present only with FLASH_MODE_EN.
- Reset (clear=0, asynchronous):
  - state=HW_GREEN, timer=T_MIN_GREEN-1, req=0, cr_elapsed=0, blink=0.
  - Outputs: highway=001, country_road=100, phase=0.
- Outputs are a Moore decode of the state register. Lamps change in the same cycle the state register changes.
- Timer:
  - On entry to state S, timer loads T_S-1.
  - Each later cycle in S, timer decrements and saturates at 0.
  - A fixed-dwell state therefore lasts exactly T_S cycles.
- req latch:
  - Set on any cycle with signal=1 while state != CR_GREEN.
  - Cleared on entry to CR_GREEN.
  - A single-cycle car pulse is never lost.
- Transitions:
  - HW_GREEN -> HW_YELLOW when timer==0 and (req or signal). Otherwise HW_GREEN holds indefinitely.
  - HW_YELLOW -> ALL_RED1 when timer==0.
  - ALL_RED1 -> CR_GREEN when timer==0.
  - CR_GREEN: cr_elapsed counts cycles in the state, starting at 0. Go to CR_YELLOW when timer==0 and (signal==0 or cr_elapsed==T_CR_MAX-1). Country green therefore lasts between T_CR_MIN and T_CR_MAX cycles.
  - CR_YELLOW -> ALL_RED2 when timer==0.
  - ALL_RED2 -> HW_GREEN when timer==0.
  - Any unused state code -> HW_GREEN next cycle, with timer reloaded.
- A car seen during CR_YELLOW or ALL_RED2 sets req. The highway still serves its full T_MIN_GREEN first.
- Reset asserted mid-phase returns immediately to HW_GREEN lamps. Reset is the only path that skips yellow/all-red.

Optional Feature:
- Macro: FLASH_MODE_EN.
- Defined:
  - The flash port exists.
  - flash=1 sampled in any state forces FLASH on the next edge, with timer=T_FLASH-1 and blink=1.
  - In FLASH: highway = YELLOW when blink=1, else 000. country_road = RED when blink=1, else 000.
  - blink toggles and the timer reloads each time timer==0.
  - flash=0 in FLASH goes to ALL_RED2 with full T_ALL_RED, then HW_GREEN.
  - req is held, not cleared, through FLASH.
- Undefined:
  - No flash port and no FLASH state.
  - Code 6 is treated as an unused code.

Test Plan (T_MIN_GREEN=4, T_YELLOW=2, T_ALL_RED=1, T_CR_MIN=3, T_CR_MAX=6; cycle 0 = first edge after reset release):
- Reset, signal=0 for 50 cycles -> highway=001, country_road=100, phase=0 throughout. Timer reads 3,2,1,0,0,...
- signal pulse 1 cycle at cycle 1 -> phase sequence 1 at cycles 4-5, 2 at 6, 3 at 7-9, 4 at 10-11, 5 at 12, 0 at 13. Country green lasts 3 cycles.
- signal held 1 from cycle 0 -> CR_GREEN lasts exactly 6 cycles (cycles 7-12), then CR_YELLOW at 13. req re-set after CR_GREEN, so HW_GREEN at 16 lasts exactly 4 cycles before HW_YELLOW.
- signal=1 only during ALL_RED2 -> HW_GREEN still lasts 4 cycles, then HW_YELLOW without further signal.
- clear=0 asserted asynchronously mid-CR_GREEN -> highway=001, country_road=100, phase=0 before the next clk edge. Timer=3 and req=0 after release.
- (FLASH_MODE_EN) flash=1 for 20 cycles from HW_GREEN -> highway alternates 010/000 every 4 cycles, country 100/000. After release, ALL_RED2 for 1 cycle, then HW_GREEN.
